// File: rtl/led_fader.sv
// led_fader: eight-channel LED PWM fader with a low-power sleep mode.
//
// Each LED bit from the data memory sets a target brightness (0 or 255).
// Per channel, a duty register walks toward its target by FADE_STEP once
// per PWM period. The PWM comparator drives the LEDs. While the CPU sits in
// wait-for-interrupt, the PWM counters freeze, the duties snap to their
// targets and the LEDs follow the register value directly, so they do not
// toggle.
//
// Parameters
//   PRESCALE  : clk cycles per PWM tick (1..65535)
//   FADE_STEP : duty change applied per PWM period (1..255)
//
// Ports
//   clk     : single system clock (HFOSC, shared with CPU and memories)
//   rst_n   : asynchronous active-low reset, release synchronised internally
//   led_in  : LED register value, sampled every cycle
//   wfi     : CPU wait-for-interrupt, high selects the sleep mode
//   led_out : registered PWM drive to the board LEDs
//   busy    : registered, high while any duty differs from its target
module led_fader #(
    parameter int unsigned PRESCALE  = 24,
    parameter int unsigned FADE_STEP = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] led_in,
    input  logic       wfi,
    output logic [7:0] led_out,
    output logic       busy
);

    typedef enum logic {
        RUN   = 1'b0,
        SLEEP = 1'b1
    } state_t;

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);
    localparam logic [8:0]  STEP      = 9'(FADE_STEP);

    state_t      state;
    state_t      state_nxt;

    // Reset release goes through one flop, so nothing updates on the first
    // edge after release and the first real update lands on the second edge.
    logic        run_en;

    logic [15:0] presc;
    logic [15:0] presc_nxt;
    logic [7:0]  pwm_cnt;
    logic [7:0]  pwm_nxt;
    logic [7:0]  led_q;
    logic [7:0]  duty     [8];
    logic [7:0]  duty_nxt [8];
    logic [7:0]  led_out_nxt;
    logic        busy_nxt;
    logic        tick;
    logic        period_end;

    // One fade step toward 0 or 255, clamped at the target; the 9-bit
    // arithmetic keeps the upward sum from wrapping past 255.
    function automatic logic [7:0] fade_step(input logic [7:0] d, input logic up);
        logic [8:0] sum;
        sum = {1'b0, d} + STEP;
        if (up) begin
            fade_step = (sum >= 9'd255) ? 8'hFF : sum[7:0];
        end else begin
            fade_step = ({1'b0, d} <= STEP) ? 8'h00 : (d - STEP[7:0]);
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
        end
    end

    always_comb begin
        tick       = (presc == PRESC_MAX);
        period_end = tick && (pwm_cnt == 8'hFF);
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:   if (wfi)  state_nxt = SLEEP;
            SLEEP: if (!wfi) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Datapath next values. Targets come from led_q, so a target change is
    // seen one cycle after led_in moves and acts at the following period_end.
    always_comb begin
        presc_nxt   = presc;
        pwm_nxt     = pwm_cnt;
        led_out_nxt = led_q;
        busy_nxt    = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            duty_nxt[i] = duty[i];
        end

        if (state == RUN) begin
            presc_nxt = tick ? 16'd0 : (presc + 16'd1);
            if (tick) begin
                pwm_nxt = pwm_cnt + 8'd1;
            end
            for (int unsigned i = 0; i < 8; i++) begin
                led_out_nxt[i] = (duty[i] == 8'hFF) || (pwm_cnt < duty[i]);
                if (period_end && (duty[i] != {8{led_q[i]}})) begin
                    duty_nxt[i] = fade_step(duty[i], led_q[i]);
                end
            end
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                duty_nxt[i] = {8{led_q[i]}};
            end
        end

        for (int unsigned i = 0; i < 8; i++) begin
            busy_nxt = busy_nxt | (duty_nxt[i] != {8{led_q[i]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            presc   <= '0;
            pwm_cnt <= '0;
            led_q   <= '0;
            led_out <= '0;
            busy    <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                duty[i] <= '0;
            end
        end else if (run_en) begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            pwm_cnt <= pwm_nxt;
            led_q   <= led_in;
            led_out <= led_out_nxt;
            busy    <= busy_nxt;
            for (int unsigned i = 0; i < 8; i++) begin
                duty[i] <= duty_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_led_fader.sv
module tb_led_fader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] led_in = 8'h00;
    logic       wfi = 1'b0;
    logic [7:0] led_out;
    logic       busy;
    logic [7:0] led_out1;
    logic       busy1;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int pe_base  = 513;

    led_fader #(.PRESCALE(2), .FADE_STEP(17)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .led_in  (led_in),
        .wfi     (wfi),
        .led_out (led_out),
        .busy    (busy)
    );

    led_fader #(.PRESCALE(1), .FADE_STEP(200)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .led_in  (8'h01),
        .wfi     (1'b0),
        .led_out (led_out1),
        .busy    (busy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Advance to just after the next period_end edge of the PRESCALE=2 DUT.
    task automatic next_pe();
        do begin
            step(1);
        end while ((cyc < pe_base) || (((cyc - pe_base) % 512) != 0));
    endtask

    task automatic sync_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        cyc = 0;
        pe_base = 513;
    endtask

    initial begin
        int ones;
        logic ok;
        logic others_off;

        // Reset state
        led_in = 8'h01;
        #2;
        check("rst_led_out", led_out, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_state", dut.state, 1'b0);
        check("rst_duty0", dut.duty[0], 8'h00);
        check("rst_pwm", dut.pwm_cnt, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc = 0;
        pe_base = 513;

        // Release: first edge does nothing, second edge updates
        step(1);
        check("rel_e1_presc", dut.presc, 16'd0);
        check("rel_e1_led_q", dut.led_q, 8'h00);
        step(1);
        check("rel_e2_presc", dut.presc, 16'd1);
        check("rel_e2_led_q", dut.led_q, 8'h01);
        check("p1_pwm_e2", dut1.pwm_cnt, 8'd1);
        step(8);
        check("p1_pwm_e10", dut1.pwm_cnt, 8'd9);
        step(247);
        check("p1_duty_first", dut1.duty[0], 8'd200);
        check("p1_busy_first", busy1, 1'b1);

        // Fade up
        next_pe();
        check("up_duty_1", dut.duty[0], 8'd17);
        check("up_busy_1", busy, 1'b1);
        check("p1_duty_sat", dut1.duty[0], 8'd255);
        check("p1_busy_sat", busy1, 1'b0);
        step(1);
        check("p1_led_on", led_out1[0], 1'b1);
        for (int k = 2; k <= 15; k++) begin
            next_pe();
            check($sformatf("up_duty_%0d", k), dut.duty[0], (17 * k > 255) ? 255 : 17 * k);
            check($sformatf("up_busy_%0d", k), busy, (k < 15) ? 1 : 0);
        end
        ok = 1'b1;
        others_off = 1'b1;
        for (int j = 0; j < 520; j++) begin
            step(1);
            if (led_out[0] !== 1'b1) ok = 1'b0;
            if (led_out[7:1] !== 7'h00) others_off = 1'b0;
        end
        check("up_steady_on", ok, 1'b1);
        check("up_others_off", others_off, 1'b1);

        // Duty compare at 34
        sync_reset();
        next_pe();
        next_pe();
        check("cmp_duty", dut.duty[0], 8'd34);
        ones = 0;
        others_off = 1'b1;
        for (int j = 1; j <= 512; j++) begin
            step(1);
            if (led_out[0] === 1'b1) ones++;
            if (led_out[7:1] !== 7'h00) others_off = 1'b0;
            if (j == 68) begin
                check("cmp_pwm_at_34", dut.pwm_cnt, 8'd34);
                check("cmp_last_high", led_out[0], 1'b1);
            end
            if (j == 69) check("cmp_first_low", led_out[0], 1'b0);
        end
        check("cmp_high_count", ones, 68);
        check("cmp_zero_off", others_off, 1'b1);
        check("cmp_duty_next", dut.duty[0], 8'd51);

        // Reversal from 85
        next_pe();
        next_pe();
        check("rev_start", dut.duty[0], 8'd85);
        led_in = 8'h00;
        for (int k = 6; k <= 10; k++) begin
            next_pe();
            check($sformatf("rev_duty_%0d", k), dut.duty[0], 85 - 17 * (k - 5));
            check($sformatf("rev_busy_%0d", k), busy, (k < 10) ? 1 : 0);
        end
        next_pe();
        check("rev_no_underflow", dut.duty[0], 8'd0);
        led_in = 8'h01;
        next_pe();
        next_pe();
        next_pe();
        check("slp_pre_duty", dut.duty[0], 8'd51);

        // Sleep mid-fade
        step(100);
        wfi = 1'b1;
        step(1);
        check("slp_state", dut.state, 1'b1);
        check("slp_pwm_entry", dut.pwm_cnt, 8'd50);
        check("slp_duty_entry", dut.duty[0], 8'd51);
        led_in = 8'hA5;
        step(1);
        check("slp_duty_snap", dut.duty[0], 8'd255);
        check("slp_led_out", led_out, 8'h01);
        check("slp_busy", busy, 1'b0);
        step(1);
        check("slp_follow", led_out, 8'hA5);
        check("slp_duty1", dut.duty[1], 8'd0);
        check("slp_duty2", dut.duty[2], 8'd255);
        step(40);
        check("slp_pwm_frozen", dut.pwm_cnt, 8'd50);
        check("slp_presc_frozen", dut.presc, 16'd1);
        check("slp_hold_led", led_out, 8'hA5);
        wfi = 1'b0;
        step(1);
        check("wake_state", dut.state, 1'b0);
        check("wake_pwm_hold", dut.pwm_cnt, 8'd50);
        step(1);
        check("wake_pwm_resume", dut.pwm_cnt, 8'd51);
        check("wake_busy", busy, 1'b0);
        pe_base += 43;
        next_pe();
        check("wake_no_step", dut.duty[0], 8'd255);

        // Asynchronous reset mid-fade
        led_in = 8'hFF;
        next_pe();
        check("ar_mid_duty1", dut.duty[1], 8'd17);
        check("ar_mid_busy", busy, 1'b1);
        step(30);
        check("ar_pre_led0", led_out[0], 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_led_out", led_out, 8'h00);
        check("ar_busy", busy, 1'b0);
        check("ar_state", dut.state, 1'b0);
        check("ar_duty1", dut.duty[1], 8'd0);
        step(3);
        rst_n = 1'b1;
        cyc = 0;
        pe_base = 513;
        for (int k = 1; k <= 15; k++) begin
            next_pe();
            if (k == 1) begin
                for (int i = 0; i < 8; i++) check($sformatf("ar_first_%0d", i), dut.duty[i], 8'd17);
            end
            if (k == 14) check("ar_busy_14", busy, 1'b1);
        end
        for (int i = 0; i < 8; i++) check($sformatf("ar_full_%0d", i), dut.duty[i], 8'd255);
        check("ar_busy_done", busy, 1'b0);
        step(1);
        check("ar_all_on", led_out, 8'hFF);

        // wfi rise coincident with period_end
        led_in = 8'h01;
        sync_reset();
        next_pe();
        check("co_duty_17", dut.duty[0], 8'd17);
        step(511);
        wfi = 1'b1;
        step(1);
        check("co_step_applied", dut.duty[0], 8'd34);
        check("co_state", dut.state, 1'b1);
        step(1);
        check("co_snap", dut.duty[0], 8'd255);
        check("co_busy", busy, 1'b0);
        step(5);
        wfi = 1'b0;
        step(2);
        check("co_wake_state", dut.state, 1'b0);
        check("co_wake_pwm", dut.pwm_cnt, 8'd0);
        check("co_wake_presc", dut.presc, 16'd1);
        pe_base += 7;
        next_pe();
        check("co_no_extra", dut.duty[0], 8'd255);
        check("co_busy_end", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
